// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream XOR engine: FSM states, bus
// mode encodings and default parameter values.
package rc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_READ,
        ST_REQ,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam int BPW_DEF      = 4;
    localparam int PIX_W_DEF    = 20;
    localparam int KS_DEPTH_DEF = 4;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            ST_READ:  mode_of = MODE_READ;
            ST_WRITE: mode_of = MODE_WRITE;
            default:  mode_of = MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small keystream byte FIFO used when keystream prefetch is enabled; flush
// empties it between passes.
module rc4_ks_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       n_rst_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!n_rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
            if (do_pop)  rd_q <= (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rc4_stream_xor.sv
// Word-at-a-time RC4 image decrypt: reads a bus word, XORs its valid bytes with
// keystream, writes it back. Define RC4_KS_PREFETCH_EN to prefetch keystream.
import rc4_pkg::*;

module rc4_stream_xor #(
    parameter int BPW      = BPW_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int KS_DEPTH = KS_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               n_rst_i,
    input  logic               start_i,
    input  logic               dfb_i,
    input  logic [8*BPW-1:0]   rdata_i,
    input  logic               sarr_generated_i,
    input  logic               val_ready_i,
    input  logic [7:0]         ks_byte_i,
    input  logic [PIX_W-1:0]   img_width_i,
    input  logic [PIX_W-1:0]   img_height_i,
    output logic [8*BPW-1:0]   wdata_o,
    output logic [PIX_W-1:0]   pix_num_o,
    output logic [1:0]         mode_o,
    output logic               done_o,
    output logic               gen_val_o,
    output logic               gen_state_arr_o,
    output logic               busy_o
);

    localparam int DW = 8 * BPW;
    localparam int TW = 2 * PIX_W;
    localparam int KW = (BPW > 1) ? $clog2(BPW) : 1;

    state_t          state_q, state_d;
    logic [TW-1:0]   total_q, total_d;
    logic [DW-1:0]   word_q, word_d;
    logic [KW-1:0]   k_q, k_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [TW:0]     idx_next, pix_adv;
    logic            ks_take;
    logic [7:0]      ks_val;

    assign pix_num_o = pix_q;

`ifdef RC4_KS_PREFETCH_EN
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]    fifo_dout;
    logic [TW-1:0] ks_req_q;
    logic          prefetch_active;

    // Requests run ahead of REQ across the whole pass, bounded by the valid byte count.
    assign prefetch_active = (state_q inside {ST_READ, ST_REQ, ST_WRITE, ST_NEXT});
    assign gen_val_o = prefetch_active && !fifo_full && (ks_req_q < total_q);
    assign fifo_push = gen_val_o && val_ready_i;
    assign fifo_pop  = (state_q == ST_REQ) && !fifo_empty;
    assign ks_take   = fifo_pop;
    assign ks_val    = fifo_dout;

    always_ff @(posedge clk) begin
        if (!n_rst_i || state_q == ST_IDLE) ks_req_q <= '0;
        else if (fifo_push)                 ks_req_q <= ks_req_q + TW'(1);
    end

    rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
        .clk     (clk),
        .n_rst_i (n_rst_i),
        .flush_i (state_q == ST_IDLE),
        .push_i  (fifo_push),
        .din_i   (ks_byte_i),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign ks_take = val_ready_i;
    assign ks_val  = ks_byte_i;
`endif

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        word_d   = word_q;
        k_d      = k_q;
        pix_d    = pix_q;
        idx_next = (TW+1)'(pix_q) + (TW+1)'(k_q) + (TW+1)'(1);
        pix_adv  = (TW+1)'(pix_q) + (TW+1)'(BPW);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    total_d = TW'(img_width_i) * TW'(img_height_i);
                    pix_d   = '0;
                    state_d = (total_d == '0) ? ST_DONE : ST_INIT;
                end
            end
            ST_INIT: begin
                if (sarr_generated_i) state_d = ST_READ;
            end
            ST_READ: begin
                if (dfb_i) begin
                    word_d  = rdata_i;
                    k_d     = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ks_take) begin
                    word_d[8*k_q +: 8] = word_q[8*k_q +: 8] ^ ks_val;
                    // Bytes past the image end are left untouched and never consume keystream.
                    if (k_q != KW'(BPW-1) && idx_next < (TW+1)'(total_q))
                        k_d = k_q + KW'(1);
                    else
                        state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (dfb_i) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                pix_d   = pix_adv[PIX_W-1:0];
                state_d = (pix_adv >= (TW+1)'(total_q)) ? ST_DONE : ST_READ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!n_rst_i) begin
            state_q         <= ST_IDLE;
            total_q         <= '0;
            word_q          <= '0;
            k_q             <= '0;
            pix_q           <= '0;
            wdata_o         <= '0;
            mode_o          <= MODE_IDLE;
            done_o          <= 1'b0;
            gen_state_arr_o <= 1'b0;
            busy_o          <= 1'b0;
`ifndef RC4_KS_PREFETCH_EN
            gen_val_o       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            total_q         <= total_d;
            word_q          <= word_d;
            k_q             <= k_d;
            pix_q           <= pix_d;
            if (state_d == ST_WRITE) wdata_o <= word_d;
            mode_o          <= mode_of(state_d);
            done_o          <= (state_d == ST_DONE);
            gen_state_arr_o <= (state_d == ST_INIT);
            busy_o          <= (state_d != ST_IDLE);
`ifndef RC4_KS_PREFETCH_EN
            gen_val_o       <= (state_d == ST_REQ);
`endif
        end
    end

endmodule
